// File: rtl/cr_huf_comp_ph_loader.sv
// cr_huf_comp_ph_loader: sequences one predefined-Huffman slot load (22 long + 48 short table writes) from a 60-bit beat stream
// Optional feature macro: CR_HUF_COMP_PH_LOADER_CHKSUM_EN (adds a 71st XOR-checksum beat verified before load_done)
// Ports:
//   i_clk, i_rst_n                      clock, synchronous active-low reset
//   i_load_req, i_load_mem_id           start request and target slot, sampled only while idle
//   i_in_vld, i_in_data, o_in_rdy       table word stream, beat accepted on i_in_vld & o_in_rdy
//   o_long_wr/addr/mem_id/data          long-table write port, registered
//   o_shrt_wr/addr/mem_id/data          short-table write port, registered
//   o_busy, o_load_done, o_load_err     status: non-idle, completion pulse, reject/fail pulse
module cr_huf_comp_ph_loader #(
  parameter int LONG_WORDS = 22,
  parameter int SHRT_WORDS = 48,
  parameter int NUM_MEM_ID = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load_req,
  input  logic [3:0]  i_load_mem_id,
  input  logic        i_in_vld,
  input  logic [59:0] i_in_data,
  output logic        o_in_rdy,
  output logic        o_long_wr,
  output logic [4:0]  o_long_addr,
  output logic [3:0]  o_long_mem_id,
  output logic [59:0] o_long_data,
  output logic        o_shrt_wr,
  output logic [5:0]  o_shrt_addr,
  output logic [3:0]  o_shrt_mem_id,
  output logic [59:0] o_shrt_data,
  output logic        o_busy,
  output logic        o_load_done,
  output logic        o_load_err
);
  typedef enum logic [2:0] {
    IDLE,
    LONG,
    SHRT,
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
    CHK,
`endif
    FIN
  } state_t;
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [3:0]  r_mem_id;
  logic        r_in_rdy;
  logic        r_long_wr;
  logic [4:0]  r_long_addr;
  logic [3:0]  r_long_mem_id;
  logic [59:0] r_long_data;
  logic        r_shrt_wr;
  logic [5:0]  r_shrt_addr;
  logic [3:0]  r_shrt_mem_id;
  logic [59:0] r_shrt_data;
  logic        r_busy;
  logic        r_load_done;
  logic        r_load_err;
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
  logic [59:0] r_csum;
`endif
  logic        w_acc;
  logic        w_id_ok;
  assign w_acc   = i_in_vld & r_in_rdy;
  assign w_id_ok = 5'(i_load_mem_id) < 5'(NUM_MEM_ID);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_mem_id      <= '0;
      r_in_rdy      <= 1'b0;
      r_long_wr     <= 1'b0;
      r_long_addr   <= '0;
      r_long_mem_id <= '0;
      r_long_data   <= '0;
      r_shrt_wr     <= 1'b0;
      r_shrt_addr   <= '0;
      r_shrt_mem_id <= '0;
      r_shrt_data   <= '0;
      r_busy        <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_long_wr   <= 1'b0;
      r_shrt_wr   <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      case (r_state)
        IDLE: if (i_load_req) begin
          if (w_id_ok) begin
            r_mem_id <= i_load_mem_id;
            r_cnt    <= '0;
            r_state  <= LONG;
            r_in_rdy <= 1'b1;
            r_busy   <= 1'b1;
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
            r_csum   <= '0;
`endif
          end else begin
            r_load_err <= 1'b1;
          end
        end
        LONG: if (w_acc) begin
          r_long_wr     <= 1'b1;
          r_long_addr   <= r_cnt[4:0];
          r_long_mem_id <= r_mem_id;
          r_long_data   <= i_in_data;
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
          r_csum        <= r_csum ^ i_in_data;
`endif
          // the short phase starts on the very next beat, no bubble
          r_cnt   <= (r_cnt == 6'(LONG_WORDS - 1)) ? '0 : r_cnt + 6'd1;
          r_state <= (r_cnt == 6'(LONG_WORDS - 1)) ? SHRT : LONG;
        end
        SHRT: if (w_acc) begin
          r_shrt_wr     <= 1'b1;
          r_shrt_addr   <= r_cnt;
          r_shrt_mem_id <= r_mem_id;
          r_shrt_data   <= i_in_data;
          r_cnt         <= (r_cnt == 6'(SHRT_WORDS - 1)) ? '0 : r_cnt + 6'd1;
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
          r_csum        <= r_csum ^ i_in_data;
          r_state       <= (r_cnt == 6'(SHRT_WORDS - 1)) ? CHK : SHRT;
`else
          r_state       <= (r_cnt == 6'(SHRT_WORDS - 1)) ? FIN : SHRT;
          r_in_rdy      <= (r_cnt != 6'(SHRT_WORDS - 1));
`endif
        end
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
        // trailing checksum beat: compared only, never written
        CHK: if (w_acc) begin
          r_in_rdy   <= 1'b0;
          r_state    <= (i_in_data == r_csum) ? FIN : IDLE;
          r_busy     <= (i_in_data == r_csum);
          r_load_err <= (i_in_data != r_csum);
        end
`endif
        FIN: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_load_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_in_rdy      = r_in_rdy;
  assign o_long_wr     = r_long_wr;
  assign o_long_addr   = r_long_addr;
  assign o_long_mem_id = r_long_mem_id;
  assign o_long_data   = r_long_data;
  assign o_shrt_wr     = r_shrt_wr;
  assign o_shrt_addr   = r_shrt_addr;
  assign o_shrt_mem_id = r_shrt_mem_id;
  assign o_shrt_data   = r_shrt_data;
  assign o_busy        = r_busy;
  assign o_load_done   = r_load_done;
  assign o_load_err    = r_load_err;
endmodule

// File: tb/tb_cr_huf_comp_ph_loader.sv
// tb_cr_huf_comp_ph_loader: randomized bench with a beat-count reference model and per-cycle output compare
module tb_cr_huf_comp_ph_loader;
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
  localparam int NB = 71;
`else
  localparam int NB = 70;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic [3:0]  load_mem_id = '0;
  logic        in_vld = 1'b0;
  logic [59:0] in_data = '0;
  logic        o_in_rdy, o_long_wr, o_shrt_wr, o_busy, o_load_done, o_load_err;
  logic [4:0]  o_long_addr;
  logic [5:0]  o_shrt_addr;
  logic [3:0]  o_long_mem_id, o_shrt_mem_id;
  logic [59:0] o_long_data, o_shrt_data;
  cr_huf_comp_ph_loader dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_req(load_req), .i_load_mem_id(load_mem_id),
    .i_in_vld(in_vld), .i_in_data(in_data), .o_in_rdy(o_in_rdy),
    .o_long_wr(o_long_wr), .o_long_addr(o_long_addr), .o_long_mem_id(o_long_mem_id), .o_long_data(o_long_data),
    .o_shrt_wr(o_shrt_wr), .o_shrt_addr(o_shrt_addr), .o_shrt_mem_id(o_shrt_mem_id), .o_shrt_data(o_shrt_data),
    .o_busy(o_busy), .o_load_done(o_load_done), .o_load_err(o_load_err)
  );
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_assert++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  // reference model: tracks beats accepted in the current load and derives the outputs for the next cycle
  int          m_k = 0;
  bit          m_load = 1'b0, m_fin = 1'b0;
  logic [3:0]  m_id = '0;
  logic [59:0] m_csum = '0;
  logic        e_rdy = 0, e_busy = 0, e_done = 0, e_err = 0, e_long_wr = 0, e_shrt_wr = 0;
  logic [4:0]  e_long_addr = '0;
  logic [5:0]  e_shrt_addr = '0;
  logic [3:0]  e_long_id = '0, e_shrt_id = '0;
  logic [59:0] e_long_data = '0, e_shrt_data = '0;
  always @(posedge clk) begin
    e_long_wr = 0; e_shrt_wr = 0; e_done = 0; e_err = 0;
    if (!rst_n) begin
      m_load = 0; m_fin = 0; m_k = 0; m_id = '0; m_csum = '0;
      e_long_addr = '0; e_shrt_addr = '0; e_long_id = '0; e_shrt_id = '0; e_long_data = '0; e_shrt_data = '0;
    end else if (m_fin) begin
      m_fin = 0; e_done = 1;
    end else if (m_load) begin
      if (in_vld) begin
        if (m_k < 22) begin
          e_long_wr = 1; e_long_addr = 5'(m_k); e_long_id = m_id; e_long_data = in_data;
        end else if (m_k < 70) begin
          e_shrt_wr = 1; e_shrt_addr = 6'(m_k - 22); e_shrt_id = m_id; e_shrt_data = in_data;
        end
        if (m_k < 70) m_csum ^= in_data;
        m_k++;
        if (m_k == NB) begin
          m_load = 0;
          if (NB == 70 || in_data == m_csum) m_fin = 1; else e_err = 1;
        end
      end
    end else if (load_req) begin
      if (load_mem_id < 4'd10) begin
        m_load = 1; m_k = 0; m_id = load_mem_id; m_csum = '0;
      end else e_err = 1;
    end
    e_rdy = m_load;
    e_busy = m_load | m_fin;
  end
  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      chk("in_rdy", 64'(o_in_rdy), 64'(e_rdy));
      chk("busy", 64'(o_busy), 64'(e_busy));
      chk("load_done", 64'(o_load_done), 64'(e_done));
      chk("load_err", 64'(o_load_err), 64'(e_err));
      chk("long_wr", 64'(o_long_wr), 64'(e_long_wr));
      chk("long_addr", 64'(o_long_addr), 64'(e_long_addr));
      chk("long_mem_id", 64'(o_long_mem_id), 64'(e_long_id));
      chk("long_data", 64'(o_long_data), 64'(e_long_data));
      chk("shrt_wr", 64'(o_shrt_wr), 64'(e_shrt_wr));
      chk("shrt_addr", 64'(o_shrt_addr), 64'(e_shrt_addr));
      chk("shrt_mem_id", 64'(o_shrt_mem_id), 64'(e_shrt_id));
      chk("shrt_data", 64'(o_shrt_data), 64'(e_shrt_data));
    end
  end
  // per-load statistics used for hand-computed expectations
  int n_long, n_shrt, n_done, n_err, n_busy, n_rdy, n_badid, last_shrt_cyc, done_cyc;
  logic [63:0] first_long_addr, first_long_data, last_long_addr, last_long_data, last_shrt_addr, last_shrt_data;
  logic [3:0]  exp_id;
  task automatic clear_stats();
    n_long = 0; n_shrt = 0; n_done = 0; n_err = 0; n_busy = 0; n_rdy = 0; n_badid = 0;
    last_shrt_cyc = 0; done_cyc = 0;
    first_long_addr = '1; first_long_data = '1; last_long_addr = '1; last_long_data = '1;
    last_shrt_addr = '1; last_shrt_data = '1;
  endtask
  always @(negedge clk) begin
    if (o_long_wr === 1'b1) begin
      if (n_long == 0) begin first_long_addr = 64'(o_long_addr); first_long_data = 64'(o_long_data); end
      n_long++; last_long_addr = 64'(o_long_addr); last_long_data = 64'(o_long_data);
      if (o_long_mem_id !== exp_id) n_badid++;
    end
    if (o_shrt_wr === 1'b1) begin
      n_shrt++; last_shrt_addr = 64'(o_shrt_addr); last_shrt_data = 64'(o_shrt_data); last_shrt_cyc = cyc;
      if (o_shrt_mem_id !== exp_id) n_badid++;
    end
    if (o_load_done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (o_load_err === 1'b1) n_err++;
    if (o_busy === 1'b1) n_busy++;
    if (o_in_rdy === 1'b1) n_rdy++;
  end
  bit flip = 1'b0;
  task automatic do_load(input logic [3:0] id, input int pct, input bit idx, input int req2_at, input int rst_at);
    logic [63:0] rnd;
    bit sent = 1'b0;
    bit ended = 1'b0;
    clear_stats();
    exp_id = id;
    @(posedge clk); #1;
    load_req = 1'b1; load_mem_id = id; in_vld = 1'b0;
    @(posedge clk); #1;
    load_req = 1'b0;
    for (int c = 0; c < 3000 && !ended; c++) begin
      load_req = 1'b0;
      if (n_done + n_err > 0) ended = 1'b1;
      else if (rst_at >= 0 && m_k == rst_at) begin
        in_vld = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        clear_stats();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_writes", 64'(n_long + n_shrt), 64'd0);
        chk("abort_done", 64'(n_done), 64'd0);
        return;
      end else begin
        in_vld = ($urandom_range(99) < pct);
        rnd = {$urandom(), $urandom()};
        in_data = (m_k == 70) ? (m_csum ^ 60'(flip)) : (idx ? 60'(m_k) : rnd[59:0]);
        if (req2_at >= 0 && m_k == req2_at && !sent) begin
          load_req = 1'b1; load_mem_id = 4'd5; sent = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    chk("load_end", 64'(ended), 64'd1);
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    clear_stats();
    exp_id = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_in_rdy", 64'(o_in_rdy), 64'd0);
    chk("rst_long_addr", 64'(o_long_addr), 64'd0);
    chk("rst_shrt_data", 64'(o_shrt_data), 64'd0);
    rst_n = 1'b1;
    do_load(4'd3, 100, 1'b1, -1, -1);
    chk("t1_n_long", 64'(n_long), 64'd22);
    chk("t1_n_shrt", 64'(n_shrt), 64'd48);
    chk("t1_first_long", first_long_data, 64'd0);
    chk("t1_last_long_addr", last_long_addr, 64'd21);
    chk("t1_last_long_data", last_long_data, 64'd21);
    chk("t1_last_shrt_addr", last_shrt_addr, 64'd47);
    chk("t1_last_shrt_data", last_shrt_data, 64'd69);
    chk("t1_done_once", 64'(n_done), 64'd1);
    chk("t1_done_lat", 64'(done_cyc - last_shrt_cyc), 64'd1);
    chk("t1_mem_id", 64'(n_badid), 64'd0);
    do_load(4'd9, 50, 1'b0, -1, -1);
    chk("t2_n_long", 64'(n_long), 64'd22);
    chk("t2_n_shrt", 64'(n_shrt), 64'd48);
    chk("t2_last_shrt_addr", last_shrt_addr, 64'd47);
    chk("t2_done_once", 64'(n_done), 64'd1);
    do_load(4'd12, 100, 1'b0, -1, -1);
    chk("t3_err_once", 64'(n_err), 64'd1);
    chk("t3_busy", 64'(n_busy), 64'd0);
    chk("t3_in_rdy", 64'(n_rdy), 64'd0);
    chk("t3_writes", 64'(n_long + n_shrt), 64'd0);
    do_load(4'd2, 100, 1'b0, 10, -1);
    chk("t4_bad_id", 64'(n_badid), 64'd0);
    chk("t4_writes", 64'(n_long + n_shrt), 64'd70);
    do_load(4'd7, 80, 1'b0, -1, 31);
    do_load(4'd0, 100, 1'b1, -1, -1);
    chk("t5_first_addr", first_long_addr, 64'd0);
    chk("t5_writes", 64'(n_long + n_shrt), 64'd70);
    chk("t5_done_once", 64'(n_done), 64'd1);
`ifdef CR_HUF_COMP_PH_LOADER_CHKSUM_EN
    flip = 1'b1;
    do_load(4'd4, 70, 1'b0, -1, -1);
    flip = 1'b0;
    chk("t6_err_once", 64'(n_err), 64'd1);
    chk("t6_no_done", 64'(n_done), 64'd0);
    chk("t6_writes", 64'(n_long + n_shrt), 64'd70);
`endif
    for (int i = 0; i < 3; i++) begin
      do_load(4'($urandom_range(9)), 60, 1'b0, -1, -1);
      chk("rand_done_once", 64'(n_done), 64'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
